// File: rtl/serializador_4bit.sv
// MSB-first parallel-to-serial transmitter with a valid strobe and an end-of-frame done pulse.
// Optional even-parity trailer bit: define SERIALIZADOR_PARITY_EN.
module serializador_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   input  logic             load,
   output logic             ready,
   output logic             out,
   output logic             valid_out,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SERIALIZADOR_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;

   function automatic logic even_parity(input logic [WIDTH-1:0] w);
      return ^w;
   endfunction
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

   state_t           state_q;
   logic [WIDTH-1:0] shreg_q;
   logic [CW-1:0]    bit_cnt_q;
   logic             ready_q;
   logic             valid_q;
   logic             done_q;
`ifdef SERIALIZADOR_PARITY_EN
   logic             par_q;
`endif

   // The serial bit is always the top of shreg_q; the parity bit is parked there for its cycle.
   assign out       = shreg_q[WIDTH-1];
   assign ready     = ready_q;
   assign valid_out = valid_q;
   assign done      = done_q;

   // Frame sequencer: state, shift register, bit counter and registered strobes.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         ready_q   <= 1'b1;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (load) begin
                  state_q   <= SHIFT;
                  shreg_q   <= d;
                  bit_cnt_q <= '0;
                  ready_q   <= 1'b0;
                  valid_q   <= 1'b1;
                  done_q    <= 1'b0;
`ifdef SERIALIZADOR_PARITY_EN
                  par_q     <= even_parity(d);
`endif
               end else begin
                  ready_q <= 1'b1;
                  valid_q <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            SHIFT: begin
               if (bit_cnt_q == LAST_CNT) begin
`ifdef SERIALIZADOR_PARITY_EN
                  state_q <= PARITY;
                  shreg_q <= {par_q, {(WIDTH-1){1'b0}}};
                  ready_q <= 1'b0;
                  valid_q <= 1'b1;
                  done_q  <= 1'b1;
`else
                  state_q <= IDLE;
                  shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                  ready_q <= 1'b1;
                  valid_q <= 1'b0;
                  done_q  <= 1'b0;
`endif
               end else begin
                  shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + CW'(1);
                  ready_q   <= 1'b0;
                  valid_q   <= 1'b1;
`ifdef SERIALIZADOR_PARITY_EN
                  done_q    <= 1'b0;
`else
                  // Pulse done for the cycle that carries the last data bit.
                  done_q    <= (bit_cnt_q == (LAST_CNT - CW'(1)));
`endif
               end
            end
`ifdef SERIALIZADOR_PARITY_EN
            PARITY: begin
               state_q <= IDLE;
               shreg_q <= '0;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
               done_q  <= 1'b0;
            end
`endif
            default: begin
               state_q   <= IDLE;
               shreg_q   <= '0;
               bit_cnt_q <= '0;
               ready_q   <= 1'b1;
               valid_q   <= 1'b0;
               done_q    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serializador_4bit.sv
// Directed bench for serializador_4bit; frame expectations widen by one bit when
// SERIALIZADOR_PARITY_EN is defined.
module tb_serializador_4bit;

`ifdef SERIALIZADOR_PARITY_EN
   localparam int FL = 5;
`else
   localparam int FL = 4;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       load;
   logic [3:0] d;
   logic       ready;
   logic       out;
   logic       valid_out;
   logic       done;
   logic [3:0] rx = 4'b0000;
   int         vectors = 0;
   int         miscompares = 0;

   serializador_4bit #(.WIDTH(4)) dut (
      .clock(clock), .reset(reset), .d(d), .load(load),
      .ready(ready), .out(out), .valid_out(valid_out), .done(done)
   );

   always #5 clock = ~clock;

   // Model of the downstream 4-bit serial-in register, clock-enabled by valid_out.
   always @(posedge clock) if (valid_out) rx <= {rx[2:0], out};

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; load = 1'b1; d = 4'b1010;
      tick; tick;
      vectors++;
      if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
      vectors++;
      if (out !== 1'b0) begin miscompares++; $display("FAIL reset_out: got %b want 0", out); end
      vectors++;
      if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
      reset = 1'b0; load = 1'b0;
      tick;
      vectors++;
      if ({valid_out, out, done, ready} !== 4'b0001)
         begin miscompares++; $display("FAIL reset_no_frame: got %b want 0001", {valid_out, out, done, ready}); end
   endtask

   task automatic test_single_frame(input logic [3:0] w, input string name);
      logic eb;
      load = 1'b1; d = w;
      tick;
      load = 1'b0;
      for (int k = 0; k < FL; k++) begin
         eb = (k < 4) ? w[3-k] : ^w;
         vectors++;
         if ({valid_out, out, done, ready} !== {1'b1, eb, (k == FL-1), 1'b0})
            begin miscompares++; $display("FAIL %s bit%0d: got v/o/d/r=%b want %b", name, k,
                  {valid_out, out, done, ready}, {1'b1, eb, (k == FL-1), 1'b0}); end
         tick;
      end
      vectors++;
      if ({valid_out, out, done, ready} !== 4'b0001)
         begin miscompares++; $display("FAIL %s end: got %b want 0001", name, {valid_out, out, done, ready}); end
`ifndef SERIALIZADOR_PARITY_EN
      vectors++;
      if (rx !== w) begin miscompares++; $display("FAIL %s rx: got %b want %b", name, rx, w); end
`endif
   endtask

   task automatic test_load_busy;
      logic [3:0] w;
      logic       eb;
      w = 4'b1011;
      load = 1'b1; d = w;
      tick;
      load = 1'b0;
      for (int k = 0; k < FL; k++) begin
         eb = (k < 4) ? w[3-k] : ^w;
         vectors++;
         if ({valid_out, out, done, ready} !== {1'b1, eb, (k == FL-1), 1'b0})
            begin miscompares++; $display("FAIL busy bit%0d: got %b want %b", k,
                  {valid_out, out, done, ready}, {1'b1, eb, (k == FL-1), 1'b0}); end
         if (k == 1) begin load = 1'b1; d = 4'b0000; end
         else load = 1'b0;
         tick;
      end
      vectors++;
      if ({valid_out, out, done, ready} !== 4'b0001)
         begin miscompares++; $display("FAIL busy ready_after_done: got %b want 0001", {valid_out, out, done, ready}); end
   endtask

   task automatic test_back_to_back;
      logic [3:0] words [2];
      logic       eb;
      words[0] = 4'b1100;
      words[1] = 4'b0011;
      for (int j = 0; j < 2; j++) begin
         load = 1'b1; d = words[j];
         tick;
         load = 1'b0; d = 4'b0101;
         for (int k = 0; k < FL; k++) begin
            eb = (k < 4) ? words[j][3-k] : ^words[j];
            vectors++;
            if ({valid_out, out, done, ready} !== {1'b1, eb, (k == FL-1), 1'b0})
               begin miscompares++; $display("FAIL b2b w%0d bit%0d: got %b want %b", j, k,
                     {valid_out, out, done, ready}, {1'b1, eb, (k == FL-1), 1'b0}); end
            tick;
         end
         vectors++;
         if ({valid_out, out, done, ready} !== 4'b0001)
            begin miscompares++; $display("FAIL b2b gap%0d: got %b want 0001", j, {valid_out, out, done, ready}); end
      end
   endtask

   task automatic test_reset_mid_frame;
      load = 1'b1; d = 4'b1111;
      tick;
      load = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({valid_out, out, done, ready} !== 4'b1100)
            begin miscompares++; $display("FAIL midrst bit%0d: got %b want 1100", k, {valid_out, out, done, ready}); end
         if (k == 2) reset = 1'b1;
         tick;
      end
      reset = 1'b0;
      vectors++;
      if ({valid_out, out, done, ready} !== 4'b0001)
         begin miscompares++; $display("FAIL midrst abort: got %b want 0001", {valid_out, out, done, ready}); end
      tick;
      vectors++;
      if ({valid_out, out, done, ready} !== 4'b0001)
         begin miscompares++; $display("FAIL midrst stay_idle: got %b want 0001", {valid_out, out, done, ready}); end
   endtask

   initial begin
      test_reset();
      test_single_frame(4'b1011, "single");
      test_load_busy();
      test_back_to_back();
      test_reset_mid_frame();
      test_single_frame(4'b0111, "w0111");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
